// File: rtl/control_sequencer_if.sv
// Bundle between the control sequencer and the datapath it steers:
// instruction/handshake inputs plus every strobe and select the FSM produces.
interface control_sequencer_if;
    logic [31:0] ir_out;
    logic        mem_ready;
    logic [4:0]  operation;
    logic        ir_write;
    logic        pc_write;
    logic [1:0]  pc_src;
    logic        i_or_d;
    logic        mem_read;
    logic        mem_write;
    logic        alu_src_b;
    logic        reg_write;
    logic [1:0]  wb_sel;
    logic        fault;
    logic [1:0]  fault_code;

    modport master (
        output ir_out, mem_ready,
        input  operation, ir_write, pc_write, pc_src, i_or_d, mem_read,
               mem_write, alu_src_b, reg_write, wb_sel, fault, fault_code
    );

    modport slave (
        input  ir_out, mem_ready,
        output operation, ir_write, pc_write, pc_src, i_or_d, mem_read,
               mem_write, alu_src_b, reg_write, wb_sel, fault, fault_code
    );
endinterface

// File: rtl/control_sequencer.sv
// Multi-cycle fetch/decode/execute/mem/writeback controller in front of the ALU.
// Strobes decode from state, the registered opcode and mem_ready; faults are sticky until reset.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// INIT      | idle cycle after reset, no strobes
// FETCH     | read instruction at PC, load IR on mem_ready
// DECODE    | latch opcode, route to EXECUTE / JUMP / FAULT
// EXECUTE   | ALU op; branches update PC and finish here
// MEM       | data read/write at ALU result; stores finish here
// WRITEBACK | register write and PC+1
// JUMP      | JAL: link PC+1 into rd, PC <= Imm
// FAULT     | illegal opcode or memory timeout, exit only through reset
module control_sequencer #(
    parameter int MEM_TIMEOUT = 16
) (
    input logic                clk,
    input logic                rst_n,
    control_sequencer_if.slave bus
);
    localparam int CW = $clog2(MEM_TIMEOUT + 1);

    localparam logic [4:0] OP_LI  = 5'b01100;
    localparam logic [4:0] OP_LUI = 5'b01101;
    localparam logic [4:0] OP_LWI = 5'b01110;
    localparam logic [4:0] OP_LW  = 5'b01111;
    localparam logic [4:0] OP_SWI = 5'b10000;
    localparam logic [4:0] OP_SW  = 5'b10001;
    localparam logic [4:0] OP_JAL = 5'b10010;

    typedef enum logic [2:0] {
        S_INIT, S_FETCH, S_DECODE, S_EXECUTE, S_MEM, S_WRITEBACK, S_JUMP, S_FAULT
    } state_t;

    state_t         state, state_nxt;
    logic [4:0]     op_q, op_nxt;
    logic [1:0]     fc_q, fc_nxt;
    logic [CW-1:0]  cnt_q, cnt_nxt;
    logic [4:0]     ir_opc;
    logic           is_load, is_store, is_branch, is_imm_b, timeout_hit;
    logic           unused_ir;

    assign ir_opc    = bus.ir_out[31:27];
    assign unused_ir = ^bus.ir_out[26:0];

    assign is_load     = (op_q == OP_LWI) || (op_q == OP_LW);
    assign is_store    = (op_q == OP_SWI) || (op_q == OP_SW);
    assign is_branch   = (op_q[4:2] == 3'b010);
    assign is_imm_b    = (op_q == OP_LI) || (op_q == OP_LUI) || is_load || (op_q == OP_SWI);
    // Fires on the MEM_TIMEOUT-th consecutive low cycle; a ready in that cycle still wins.
    assign timeout_hit = (cnt_q == CW'(MEM_TIMEOUT - 1)) && !bus.mem_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_INIT;
            op_q  <= '0;
            fc_q  <= '0;
            cnt_q <= '0;
        end else begin
            state <= state_nxt;
            op_q  <= op_nxt;
            fc_q  <= fc_nxt;
            cnt_q <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        op_nxt        = op_q;
        fc_nxt        = fc_q;
        bus.ir_write  = 1'b0;
        bus.pc_write  = 1'b0;
        bus.pc_src    = 2'b00;
        bus.i_or_d    = 1'b0;
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
        bus.alu_src_b = 1'b0;
        bus.reg_write = 1'b0;
        bus.wb_sel    = 2'b00;
        bus.fault     = 1'b0;
        case (state)
            S_INIT: state_nxt = S_FETCH;
            S_FETCH: begin
                bus.mem_read = 1'b1;
                if (bus.mem_ready) begin
                    bus.ir_write = 1'b1;
                    state_nxt    = S_DECODE;
                end else if (timeout_hit) begin
                    state_nxt = S_FAULT;
                    fc_nxt    = 2'b10;
                end
            end
            S_DECODE: begin
                op_nxt = ir_opc;
                if (ir_opc > OP_JAL) begin
                    state_nxt = S_FAULT;
                    fc_nxt    = 2'b01;
                end else if (ir_opc == OP_JAL) begin
                    state_nxt = S_JUMP;
                end else begin
                    state_nxt = S_EXECUTE;
                end
            end
            S_EXECUTE: begin
                bus.alu_src_b = is_imm_b;
                if (is_branch) begin
                    bus.pc_write = 1'b1;
                    bus.pc_src   = 2'b01;
                    state_nxt    = S_FETCH;
                end else if (is_load || is_store) begin
                    state_nxt = S_MEM;
                end else begin
                    state_nxt = S_WRITEBACK;
                end
            end
            S_MEM: begin
                bus.i_or_d    = 1'b1;
                bus.alu_src_b = is_imm_b;
                if (is_load) begin
                    bus.mem_read = 1'b1;
                    if (bus.mem_ready) state_nxt = S_WRITEBACK;
                end else begin
                    bus.mem_write = 1'b1;
                    if (bus.mem_ready) begin
                        bus.pc_write = 1'b1;
                        state_nxt    = S_FETCH;
                    end
                end
                if (timeout_hit) begin
                    state_nxt = S_FAULT;
                    fc_nxt    = 2'b10;
                end
            end
            S_WRITEBACK: begin
                bus.reg_write = 1'b1;
                bus.pc_write  = 1'b1;
                bus.wb_sel    = is_load ? 2'b01 : 2'b00;
                state_nxt     = S_FETCH;
            end
            S_JUMP: begin
                bus.reg_write = 1'b1;
                bus.wb_sel    = 2'b10;
                bus.pc_write  = 1'b1;
                bus.pc_src    = 2'b10;
                state_nxt     = S_FETCH;
            end
            default: bus.fault = 1'b1;
        endcase
    end

    always_comb begin
        cnt_nxt = '0;
        if ((state == S_FETCH || state == S_MEM) && !bus.mem_ready && state_nxt == state)
            cnt_nxt = cnt_q + CW'(1);
    end

    assign bus.operation  = op_q;
    assign bus.fault_code = fc_q;
endmodule
